// File: rtl/tdc_multi_shot.sv
`default_nettype none
// tdc_multi_shot: tapped cinv delay-line TDC with two-flop capture, thermometer encoder,
// timeout and 2^AVG_LOG2 shot averaging. Optional macro TDC_BUBBLE_FIX_EN selects the majority-filter encoder.

module cinv (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module tdc_multi_shot #(
  parameter int N_TAPS      = 32,
  parameter int INV_PER_TAP = 2,
  parameter int AVG_LOG2    = 2,
  parameter int DRAIN_CYC   = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int CODE_W      = $clog2(N_TAPS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       hit,
  output logic                       busy,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [CODE_W+AVG_LOG2-1:0] result_sum,
  output logic [CODE_W-1:0]          result_mean,
  output logic                       result_ovf,
  output logic                       result_tmo
);
  localparam int N_CELLS = N_TAPS * INV_PER_TAP;
  localparam int SUM_W   = CODE_W + AVG_LOG2;
  localparam int SHOT_W  = AVG_LOG2 + 1;
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int DRN_W   = $clog2(DRAIN_CYC + 1);
  localparam logic [SHOT_W-1:0] N_SHOTS = SHOT_W'(2 ** AVG_LOG2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    ENC     = 3'd2,
    ENC2    = 3'd3,
    DRAIN   = 3'd4,
    WAITLOW = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t              state, state_next;
  logic                gate_en;
  logic                line_in;
  logic [N_TAPS-1:0]   taps;
  logic [N_TAPS-1:0]   cap1, cap2, snap;
  logic [CODE_W-1:0]   code;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [DRN_W-1:0]    drn_cnt;
  logic [SHOT_W-1:0]   shots;
  logic [SUM_W-1:0]    acc;
  logic                ovf_flag, tmo_flag;
  logic                tmo_last, drn_last;
`ifdef TDC_BUBBLE_FIX_EN
  logic [CODE_W-1:0]   code_q;
`endif

  assign line_in = hit & gate_en;

  // Each cell gets its own net so the chain is not one self-dependent vector.
  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    logic y;
    if (i == 0) begin : g_first
      cinv u_inv (.a(line_in), .y(y));
    end else begin : g_next
      cinv u_inv (.a(g_cell[i-1].y), .y(y));
    end
  end

  for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
    assign taps[k] = g_cell[(k+1)*INV_PER_TAP-1].y;
  end

  function automatic logic [CODE_W-1:0] encode(input logic [N_TAPS-1:0] c);
    logic [CODE_W-1:0] n;
`ifdef TDC_BUBBLE_FIX_EN
    logic [N_TAPS+1:0] e;
    logic              found;
    e     = {1'b0, c, 1'b1};
    n     = CODE_W'(N_TAPS);
    found = 1'b0;
    for (int k = 0; k < N_TAPS; k++) begin
      if (!((e[k] & e[k+1]) | (e[k] & e[k+2]) | (e[k+1] & e[k+2])) && !found) begin
        n     = CODE_W'(k);
        found = 1'b1;
      end
    end
`else
    n = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      n = n + CODE_W'(c[k]);
    end
`endif
    return n;
  endfunction

  assign code     = encode(snap);
  assign tmo_last = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign drn_last = (drn_cnt == DRN_W'(DRAIN_CYC - 1));
  assign busy     = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (arm) state_next = ARMED;
      end
      ARMED: begin
        if (cap2[0])       state_next = ENC;
        else if (tmo_last) state_next = DRAIN;
      end
`ifdef TDC_BUBBLE_FIX_EN
      ENC:  state_next = ENC2;
      ENC2: state_next = DRAIN;
`else
      ENC:  state_next = DRAIN;
`endif
      DRAIN: begin
        if (drn_last) state_next = (shots == N_SHOTS) ? DONE : WAITLOW;
      end
      WAITLOW: begin
        if (cap2 == '0) state_next = ARMED;
      end
      DONE: begin
        if (result_valid && result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap1         <= '0;
      cap2         <= '0;
      snap         <= '0;
      gate_en      <= 1'b0;
      tmo_cnt      <= '0;
      drn_cnt      <= '0;
      shots        <= '0;
      acc          <= '0;
      ovf_flag     <= 1'b0;
      tmo_flag     <= 1'b0;
      result_valid <= 1'b0;
      result_sum   <= '0;
      result_mean  <= '0;
      result_ovf   <= 1'b0;
      result_tmo   <= 1'b0;
`ifdef TDC_BUBBLE_FIX_EN
      code_q       <= '0;
`endif
    end else begin
      cap1    <= taps;
      cap2    <= cap1;
      drn_cnt <= (state == DRAIN) ? drn_cnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (arm) begin
            gate_en     <= 1'b1;
            acc         <= '0;
            ovf_flag    <= 1'b0;
            tmo_flag    <= 1'b0;
            shots       <= '0;
            tmo_cnt     <= '0;
            result_sum  <= '0;
            result_mean <= '0;
            result_ovf  <= 1'b0;
            result_tmo  <= 1'b0;
          end
        end
        ARMED: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // Freeze the triggering sample; later samples only show the edge having run further.
          if (cap2[0]) begin
            snap <= cap2;
          end else if (tmo_last) begin
            tmo_flag <= 1'b1;
            gate_en  <= 1'b0;
            shots    <= shots + 1'b1;
          end
        end
`ifdef TDC_BUBBLE_FIX_EN
        ENC: begin
          gate_en <= 1'b0;
          code_q  <= code;
        end
        ENC2: begin
          acc   <= acc + SUM_W'(code_q);
          shots <= shots + 1'b1;
          if (code_q == CODE_W'(N_TAPS)) ovf_flag <= 1'b1;
        end
`else
        ENC: begin
          gate_en <= 1'b0;
          acc     <= acc + SUM_W'(code);
          shots   <= shots + 1'b1;
          if (code == CODE_W'(N_TAPS)) ovf_flag <= 1'b1;
        end
`endif
        DRAIN: begin
          if (drn_last && shots == N_SHOTS) begin
            result_valid <= 1'b1;
            result_sum   <= acc;
            result_mean  <= CODE_W'(acc >> AVG_LOG2);
            result_ovf   <= ovf_flag;
            result_tmo   <= tmo_flag;
          end
        end
        WAITLOW: begin
          if (cap2 == '0) begin
            gate_en <= 1'b1;
            tmo_cnt <= '0;
          end
        end
        DONE: begin
          if (result_ready) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_tdc_multi_shot.sv
`default_nettype none
// tb_tdc_multi_shot: table-driven and randomized 4-shot bursts checked against a shot-level model,
// plus backpressure and mid-burst reset sequences.

module tb_tdc_multi_shot;
  localparam int N_TAPS = 32;
  localparam int TMO    = 12;
  localparam int SUM_W  = 8;
  localparam int CODE_W = 6;
`ifdef TDC_BUBBLE_FIX_EN
  localparam int BUB_CODE = 6;
`else
  localparam int BUB_CODE = 5;
`endif
  localparam logic [1:0] K_FORCE = 2'd0;
  localparam logic [1:0] K_HIT   = 2'd1;
  localparam logic [1:0] K_TMO   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pat;
  } shot_t;

  typedef struct packed {
    shot_t [3:0] sh;
    logic [7:0]  sum;
    logic [5:0]  mean;
    logic        ovf;
    logic        tmo;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst, arm, hit, result_ready;
  logic              busy, result_valid, result_ovf, result_tmo;
  logic [SUM_W-1:0]  result_sum;
  logic [CODE_W-1:0] result_mean;
  logic [31:0]       force_pat;
  int                total = 0;
  int                bad   = 0;

  tdc_multi_shot #(
    .N_TAPS(N_TAPS), .INV_PER_TAP(2), .AVG_LOG2(2), .DRAIN_CYC(4), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .hit(hit), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_sum(result_sum), .result_mean(result_mean),
    .result_ovf(result_ovf), .result_tmo(result_tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic shot_t mk(input logic [1:0] k, input logic [31:0] p);
    shot_t s;
    s.kind = k;
    s.pat  = p;
    return s;
  endfunction

  // Code the design should report for a captured tap pattern.
  function automatic int model_code(input logic [31:0] c);
`ifdef TDC_BUBBLE_FIX_EN
    logic [33:0] e;
    int          votes;
    e = {1'b0, c, 1'b1};
    for (int k = 0; k < N_TAPS; k++) begin
      votes = int'(e[k]) + int'(e[k+1]) + int'(e[k+2]);
      if (votes < 2) return k;
    end
    return N_TAPS;
`else
    return $countones(c);
`endif
  endfunction

  task automatic wait_gate(input logic lvl, input int limit, input string name);
    int n = 0;
    while (dut.gate_en !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (dut.gate_en !== lvl) begin
      total++;
      bad++;
      $display("FAIL %s: gate_en stuck at %0b, expected %0b", name, dut.gate_en, lvl);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (result_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (result_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL valid_wait: result_valid got %0b, expected 1", result_valid);
    end
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("busy_after_arm", busy, 1);
  endtask

  task automatic do_shot(input logic [1:0] kind, input logic [31:0] pat);
    wait_gate(1'b1, 100, "shot_arm");
    if (kind == K_FORCE) begin
      force_pat = pat;
      force dut.taps = force_pat;
      repeat (3) @(negedge clk);
      release dut.taps;
    end else if (kind == K_HIT) begin
      hit = 1'b1;
      repeat (3) @(negedge clk);
      hit = 1'b0;
    end
    wait_gate(1'b0, TMO + 20, "shot_end");
  endtask

  task automatic run_burst(input shot_t [3:0] sh);
    arm_pulse();
    for (int i = 0; i < 4; i++) do_shot(sh[i].kind, sh[i].pat);
    wait_valid();
  endtask

  task automatic check_result(input string tag, input int s, input int m, input int o, input int t);
    check({tag, "_sum"},  result_sum,  s);
    check({tag, "_mean"}, result_mean, m);
    check({tag, "_ovf"},  result_ovf,  o);
    check({tag, "_tmo"},  result_tmo,  t);
  endtask

  task automatic accept(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, "_valid_clr"}, result_valid, 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    vec_t        tbl [7];
    shot_t [3:0] sh;
    logic [32:0] wide;
    logic [31:0] p;
    logic [1:0]  kind;
    int          s, o, t, c, k, r, idx;

    rst = 1'b1; arm = 1'b0; hit = 1'b0; result_ready = 1'b0; force_pat = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  busy, 0);
    check("rst_valid", result_valid, 0);
    check_result("rst", 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    tbl[0].sh = {mk(K_FORCE, 32'hFF), mk(K_FORCE, 32'h7F), mk(K_FORCE, 32'h3F), mk(K_FORCE, 32'h1F)};
    tbl[0].sum = 8'd26;  tbl[0].mean = 6'd6;  tbl[0].ovf = 1'b0; tbl[0].tmo = 1'b0;
    tbl[1].sh = {mk(K_FORCE, 32'h7), mk(K_FORCE, 32'h1), mk(K_FORCE, 32'h3FF), mk(K_HIT, 32'h0)};
    tbl[1].sum = 8'd46;  tbl[1].mean = 6'd11; tbl[1].ovf = 1'b1; tbl[1].tmo = 1'b0;
    tbl[2].sh = {mk(K_FORCE, 32'h3FF), mk(K_FORCE, 32'h3FF), mk(K_FORCE, 32'h3FF), mk(K_TMO, 32'h0)};
    tbl[2].sum = 8'd30;  tbl[2].mean = 6'd7;  tbl[2].ovf = 1'b0; tbl[2].tmo = 1'b1;
    tbl[3].sh = {4{mk(K_TMO, 32'h0)}};
    tbl[3].sum = 8'd0;   tbl[3].mean = 6'd0;  tbl[3].ovf = 1'b0; tbl[3].tmo = 1'b1;
    tbl[4].sh = {4{mk(K_FORCE, 32'hFFFF_FFFF)}};
    tbl[4].sum = 8'd128; tbl[4].mean = 6'd32; tbl[4].ovf = 1'b1; tbl[4].tmo = 1'b0;
    tbl[5].sh = {mk(K_FORCE, 32'h0FFF_FFFF), mk(K_FORCE, 32'h7FFF), mk(K_FORCE, 32'h3), mk(K_FORCE, 32'h37)};
    tbl[5].sum = 8'(BUB_CODE + 45); tbl[5].mean = 6'd12; tbl[5].ovf = 1'b0; tbl[5].tmo = 1'b0;
    tbl[6].sh = {4{mk(K_HIT, 32'h0)}};
    tbl[6].sum = 8'd128; tbl[6].mean = 6'd32; tbl[6].ovf = 1'b1; tbl[6].tmo = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_burst(tbl[i].sh);
      check_result($sformatf("tbl%0d", i), int'(tbl[i].sum), int'(tbl[i].mean),
                   int'(tbl[i].ovf), int'(tbl[i].tmo));
      accept($sformatf("tbl%0d", i));
    end

    // Backpressure: result held, arm ignored while DONE.
    sh = {4{mk(K_FORCE, 32'h1F)}};
    run_burst(sh);
    for (int cyc = 0; cyc < 10; cyc++) begin
      arm = (cyc == 3 || cyc == 6) ? 1'b1 : 1'b0;
      @(negedge clk);
      check("bp_valid", result_valid, 1);
      check("bp_sum",   result_sum, 20);
      check("bp_busy",  busy, 0);
    end
    arm = 1'b0;
    check("bp_mean", result_mean, 5);
    accept("bp");
    check("bp_hold_sum", result_sum, 20);

    // Reset during DRAIN of the first shot.
    arm_pulse();
    do_shot(K_FORCE, 32'h3FF);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy",  busy, 0);
    check("rst_mid_valid", result_valid, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_no_result", result_valid, 0);
    run_burst(tbl[0].sh);
    check_result("after_rst", 26, 6, 0, 0);
    accept("after_rst");

    for (int b = 0; b < 25; b++) begin
      s = 0; o = 0; t = 0;
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 99);
        kind = (r < 70) ? K_FORCE : (r < 85) ? K_HIT : K_TMO;
        k = $urandom_range(1, 32);
        wide = (33'd1 << k) - 33'd1;
        p = wide[31:0];
        if ($urandom_range(0, 1) == 1) begin
          idx = $urandom_range(1, 31);
          p[idx] = ~p[idx];
        end
        sh[i] = mk(kind, p);
        c = (kind == K_HIT) ? N_TAPS : (kind == K_TMO) ? 0 : model_code(p);
        s += c;
        if (c == N_TAPS) o = 1;
        if (kind == K_TMO) t = 1;
      end
      run_burst(sh);
      check_result($sformatf("rnd%0d", b), s, s >> 2, o, t);
      accept($sformatf("rnd%0d", b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
